// File: rtl/hazard_scoreboard_fwd_pkg.sv
// Shared core constants: datapath/register-file sizing, the x0 index and
// the nominal result latencies of the execution units.
package hazard_scoreboard_fwd_pkg;

  localparam int RV_XLEN  = 32;
  localparam int RV_NREG  = 32;
  localparam int RV_AW    = $clog2(RV_NREG);
  localparam int RV_LAT_W = 4;

  localparam logic [RV_AW-1:0] X0_IDX = {RV_AW{1'b0}};

  localparam logic [RV_LAT_W-1:0] LAT_ALU  = 4'd0;
  localparam logic [RV_LAT_W-1:0] LAT_LOAD = 4'd1;
  localparam logic [RV_LAT_W-1:0] LAT_MUL  = 4'd3;
  localparam logic [RV_LAT_W-1:0] LAT_DIV  = 4'd8;

  typedef logic [RV_AW-1:0] reg_idx_t;

endpackage

// File: rtl/hazard_scoreboard_fwd_if.sv
// Issue-side bundle between decode/issue (master) and the hazard unit (slave).
interface hazard_scoreboard_fwd_if
  import hazard_scoreboard_fwd_pkg::*;
#(
  parameter int XLEN  = RV_XLEN,
  parameter int AW    = RV_AW,
  parameter int NSRC  = 2,
  parameter int LAT_W = RV_LAT_W
);
  logic                 issue_valid;
  logic                 issue_regwrite;
  logic [AW-1:0]        issue_rd;
  logic [LAT_W-1:0]     issue_lat;
  logic [NSRC*AW-1:0]   issue_src;
  logic [NSRC-1:0]      issue_src_used;
  logic                 issue_stall;
  logic [NSRC*XLEN-1:0] src_raw_data;
  logic [NSRC*XLEN-1:0] src_data;

  modport master (
    output issue_valid, issue_regwrite, issue_rd, issue_lat,
           issue_src, issue_src_used, src_raw_data,
    input  issue_stall, src_data
  );

  modport slave (
    input  issue_valid, issue_regwrite, issue_rd, issue_lat,
           issue_src, issue_src_used, src_raw_data,
    output issue_stall, src_data
  );
endinterface

// File: rtl/hazard_scoreboard_fwd_mux_prio.sv
// One source operand: priority forward mux over NFWD ports (port 0 wins),
// falling back to register-file data; x0 always reads as zero.
module hazard_scoreboard_fwd_mux_prio #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NFWD = 2
) (
  input  logic [AW-1:0]        src_i,
  input  logic [XLEN-1:0]      raw_i,
  input  logic [NFWD-1:0]      fwd_valid_i,
  input  logic [NFWD*AW-1:0]   fwd_rd_i,
  input  logic [NFWD*XLEN-1:0] fwd_data_i,
  output logic [XLEN-1:0]      data_o
);

  logic found_s;

  // Pick the youngest matching port; a port writing x0 never matches.
  always_comb begin
    data_o  = raw_i;
    found_s = 1'b0;
    for (int i = 0; i < NFWD; i++) begin
      if (!found_s && fwd_valid_i[i] &&
          (fwd_rd_i[i*AW +: AW] == src_i) &&
          (fwd_rd_i[i*AW +: AW] != {AW{1'b0}})) begin
        data_o  = fwd_data_i[i*XLEN +: XLEN];
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
    if (src_i == {AW{1'b0}}) begin
      data_o = {XLEN{1'b0}};
    end else begin
      data_o = data_o;
    end
  end

endmodule

// File: rtl/hazard_scoreboard_fwd.sv
// Register scoreboard with variable-latency countdown, RAW/WAW issue stall,
// saturating stall counter and per-source priority operand forwarding.
module hazard_scoreboard_fwd
  import hazard_scoreboard_fwd_pkg::*;
#(
  parameter  int XLEN  = RV_XLEN,
  parameter  int NREG  = RV_NREG,
  parameter  int NSRC  = 2,
  parameter  int NFWD  = 2,
  parameter  int LAT_W = RV_LAT_W,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  hazard_scoreboard_fwd_if.slave iss,
  input  logic [NFWD-1:0]       fwd_valid,
  input  logic [NFWD*AW-1:0]    fwd_rd,
  input  logic [NFWD*XLEN-1:0]  fwd_data,
  input  logic                  retire_valid,
  input  logic [AW-1:0]         retire_rd,
  input  logic                  flush,
  output logic [31:0]           stall_cycles
);

  logic [NREG-1:0]  busy_q, busy_d;
  logic [LAT_W-1:0] cnt_q [NREG];
  logic [LAT_W-1:0] cnt_d [NREG];
  logic [31:0]      stall_cycles_q, stall_cycles_d;
  logic [AW-1:0]    src_a  [NSRC];
  logic [XLEN-1:0]  data_a [NSRC];
  logic             raw_s, waw_s, stall_s, fire_s;

  function automatic logic [LAT_W-1:0] dec_sat(input logic [LAT_W-1:0] v);
    if (v != {LAT_W{1'b0}}) begin
      return v - {{(LAT_W-1){1'b0}}, 1'b1};
    end else begin
      return v;
    end
  endfunction

  // RAW on any pending source, WAW if an older write would land after this one.
  always_comb begin
    raw_s = 1'b0;
    for (int s = 0; s < NSRC; s++) begin
      if (iss.issue_src_used[s] && (src_a[s] != {AW{1'b0}}) &&
          busy_q[src_a[s]] && (cnt_q[src_a[s]] != {LAT_W{1'b0}})) begin
        raw_s = 1'b1;
      end else begin
        raw_s = raw_s;
      end
    end
    waw_s   = iss.issue_regwrite && (iss.issue_rd != {AW{1'b0}}) &&
              busy_q[iss.issue_rd] && (cnt_q[iss.issue_rd] > iss.issue_lat);
    stall_s = iss.issue_valid && (raw_s || waw_s);
    fire_s  = iss.issue_valid && !stall_s && iss.issue_regwrite &&
              (iss.issue_rd != {AW{1'b0}});
  end

  // Scoreboard next state: countdown, then retire, then fire (fire wins); flush clears all.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      busy_d[r] = busy_q[r];
      cnt_d[r]  = busy_q[r] ? dec_sat(cnt_q[r]) : cnt_q[r];
    end
    if (flush) begin
      busy_d = {NREG{1'b0}};
      for (int r = 0; r < NREG; r++) begin
        cnt_d[r] = {LAT_W{1'b0}};
      end
    end else begin
      if (retire_valid && (retire_rd != {AW{1'b0}})) begin
        busy_d[retire_rd] = 1'b0;
        cnt_d[retire_rd]  = {LAT_W{1'b0}};
      end else begin
        busy_d = busy_d;
      end
      if (fire_s) begin
        busy_d[iss.issue_rd] = 1'b1;
        cnt_d[iss.issue_rd]  = iss.issue_lat;
      end else begin
        busy_d = busy_d;
      end
    end
    busy_d[0] = 1'b0;
    cnt_d[0]  = {LAT_W{1'b0}};
  end

  // Saturating count of cycles in which issue was held.
  always_comb begin
    if (stall_s && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q         <= {NREG{1'b0}};
      stall_cycles_q <= 32'd0;
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= {LAT_W{1'b0}};
      end
    end else begin
      busy_q         <= busy_d;
      stall_cycles_q <= stall_cycles_d;
      cnt_q          <= cnt_d;
    end
  end

  for (genvar s = 0; s < NSRC; s++) begin : g_src
    assign src_a[s] = iss.issue_src[s*AW +: AW];

    hazard_scoreboard_fwd_mux_prio #(
      .XLEN (XLEN),
      .AW   (AW),
      .NFWD (NFWD)
    ) u_mux (
      .src_i       (src_a[s]),
      .raw_i       (iss.src_raw_data[s*XLEN +: XLEN]),
      .fwd_valid_i (fwd_valid),
      .fwd_rd_i    (fwd_rd),
      .fwd_data_i  (fwd_data),
      .data_o      (data_a[s])
    );
  end

  // Pack per-source operands onto the interface bus.
  always_comb begin
    iss.src_data = {(NSRC*XLEN){1'b0}};
    for (int s = 0; s < NSRC; s++) begin
      iss.src_data[s*XLEN +: XLEN] = data_a[s];
    end
  end

  assign iss.issue_stall = stall_s;
  assign stall_cycles    = stall_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard_fwd.sv
// Bench for hazard_scoreboard_fwd: forwarding vector table, directed
// multi-cycle hazard sequences and a randomized run against a
// ready-time reference model.
module tb_hazard_scoreboard_fwd;
  import hazard_scoreboard_fwd_pkg::*;

  localparam int XLEN = 32, AW = 5, NSRC = 2, NFWD = 2, LAT_W = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NFWD-1:0]      fwd_valid;
  logic [NFWD*AW-1:0]   fwd_rd;
  logic [NFWD*XLEN-1:0] fwd_data;
  logic                 retire_valid;
  logic [AW-1:0]        retire_rd;
  logic                 flush;
  logic [31:0]          stall_cycles;

  hazard_scoreboard_fwd_if #(.XLEN(XLEN), .AW(AW), .NSRC(NSRC), .LAT_W(LAT_W)) iss ();

  hazard_scoreboard_fwd #(.XLEN(XLEN), .NREG(32), .NSRC(NSRC), .NFWD(NFWD), .LAT_W(LAT_W)) dut (
    .clk(clk), .rst_n(rst_n), .iss(iss),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .retire_valid(retire_valid), .retire_rd(retire_rd),
    .flush(flush), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int exp_sc = 0;

  typedef struct {
    logic [AW-1:0]   src0, src1;
    logic [1:0]      fv;
    logic [AW-1:0]   frd0, frd1;
    logic [XLEN-1:0] fd0, fd1, raw0, raw1, exp0, exp1;
  } vec_t;
  vec_t tv [7];

  // reference model state: in-flight flag and absolute cycle the result becomes forwardable
  bit      busy_m  [32];
  longint  ready_m [32];
  longint  now;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    iss.issue_valid = 1'b0; iss.issue_regwrite = 1'b0; iss.issue_rd = '0;
    iss.issue_lat = '0; iss.issue_src = '0; iss.issue_src_used = '0;
    iss.src_raw_data = '0;
    fwd_valid = '0; fwd_rd = '0; fwd_data = '0;
    retire_valid = 1'b0; retire_rd = '0; flush = 1'b0;
  endtask

  task automatic issue_w(input logic [AW-1:0] rd, input logic [LAT_W-1:0] lat);
    idle();
    iss.issue_valid = 1'b1; iss.issue_regwrite = 1'b1; iss.issue_rd = rd; iss.issue_lat = lat;
  endtask

  task automatic use_src(input logic [AW-1:0] s0, input logic [AW-1:0] s1);
    idle();
    iss.issue_valid = 1'b1; iss.issue_src = {s1, s0}; iss.issue_src_used = 2'b11;
  endtask

  // check stall for this cycle, then advance to the next negedge
  task automatic step(input string nm, input logic exp_stall);
    #1;
    chk(nm, {31'd0, iss.issue_stall}, {31'd0, exp_stall});
    if (exp_stall) exp_sc++;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic clear_sb();
    idle(); flush = 1'b1;
    @(posedge clk); @(negedge clk);
    flush = 1'b0;
  endtask

  initial begin
    int n;
    logic exp_stall, raw_h, waw_h, fire;
    logic [AW-1:0] s;
    logic [XLEN-1:0] ed;

    tv[0] = '{5'd0,  5'd4,  2'b01, 5'd0,  5'd0, 32'hFF, 32'h0, 32'h11, 32'h22, 32'h0, 32'h22};
    tv[1] = '{5'd4,  5'd4,  2'b11, 5'd4,  5'd4, 32'hA, 32'hB, 32'h11, 32'h22, 32'hA, 32'hA};
    tv[2] = '{5'd4,  5'd5,  2'b10, 5'd4,  5'd5, 32'hA, 32'hB, 32'h11, 32'h22, 32'h11, 32'hB};
    tv[3] = '{5'd3,  5'd3,  2'b00, 5'd3,  5'd3, 32'hA, 32'hB, 32'h33, 32'h44, 32'h33, 32'h44};
    tv[4] = '{5'd0,  5'd0,  2'b11, 5'd0,  5'd0, 32'hA, 32'hB, 32'h55, 32'h66, 32'h0, 32'h0};
    tv[5] = '{5'd7,  5'd2,  2'b11, 5'd2,  5'd7, 32'hC2, 32'hC7, 32'h1, 32'h2, 32'hC7, 32'hC2};
    tv[6] = '{5'd31, 5'd30, 2'b01, 5'd31, 5'd30, 32'hDEADBEEF, 32'hB, 32'h9, 32'h8, 32'hDEADBEEF, 32'h8};

    idle();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_stall_cycles", stall_cycles, 32'd0);
    chk("reset_issue_stall", {31'd0, iss.issue_stall}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // forwarding table on an empty scoreboard
    for (int i = 0; i < 7; i++) begin
      use_src(tv[i].src0, tv[i].src1);
      iss.src_raw_data = {tv[i].raw1, tv[i].raw0};
      fwd_valid = tv[i].fv; fwd_rd = {tv[i].frd1, tv[i].frd0}; fwd_data = {tv[i].fd1, tv[i].fd0};
      #1;
      chk($sformatf("tab%0d_src0", i), iss.src_data[31:0], tv[i].exp0);
      chk($sformatf("tab%0d_src1", i), iss.src_data[63:32], tv[i].exp1);
      chk($sformatf("tab%0d_stall", i), {31'd0, iss.issue_stall}, 32'd0);
      @(negedge clk);
    end

    // ALU back-to-back
    issue_w(5'd5, LAT_ALU); step("alu_fire", 1'b0);
    use_src(5'd5, 5'd0); fwd_valid = 2'b01; fwd_rd = {5'd0, 5'd5}; fwd_data = {32'h0, 32'h1234};
    #1; chk("alu_fwd_data", iss.src_data[31:0], 32'h1234);
    step("alu_use", 1'b0);

    // load-use
    clear_sb();
    issue_w(5'd7, LAT_LOAD); step("ld_fire", 1'b0);
    use_src(5'd7, 5'd0); fwd_valid = 2'b01; fwd_rd = {5'd0, 5'd7}; fwd_data = {32'h0, 32'h55};
    step("ld_use_stall", 1'b1);
    #1; chk("ld_fwd_data", iss.src_data[31:0], 32'h55);
    step("ld_use_go", 1'b0);
    chk("ld_stall_cycles", stall_cycles, exp_sc);

    // divider, with an independent source held behind it
    clear_sb();
    issue_w(5'd9, LAT_DIV); step("div_fire", 1'b0);
    use_src(5'd3, 5'd9);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (!iss.issue_stall) break;
      n++;
      @(posedge clk); @(negedge clk);
    end
    chk("div_stall_len", n, 32'd8);
    exp_sc += 8;
    @(posedge clk); @(negedge clk);
    chk("div_stall_cycles", stall_cycles, exp_sc);

    // WAW
    clear_sb();
    issue_w(5'd6, 4'd6); step("waw_first", 1'b0);
    issue_w(5'd6, 4'd0); step("waw_younger_stall", 1'b1);
    issue_w(5'd6, 4'd5); step("waw_equal_ok", 1'b0);
    // fire and retire on the same register: fire wins
    clear_sb();
    issue_w(5'd6, 4'd3); retire_valid = 1'b1; retire_rd = 5'd6; step("fr_fire", 1'b0);
    use_src(5'd6, 5'd0); step("fr_busy_stall", 1'b1);

    // flush
    clear_sb();
    issue_w(5'd9, LAT_DIV); step("fl_fire", 1'b0);
    use_src(5'd9, 5'd0); flush = 1'b1; step("fl_during", 1'b1);
    use_src(5'd9, 5'd0); step("fl_after", 1'b0);
    issue_w(5'd10, 4'd5); flush = 1'b1; step("fl_discard_fire", 1'b0);
    use_src(5'd10, 5'd0); step("fl_discarded", 1'b0);
    chk("fl_stall_cycles", stall_cycles, exp_sc);

    // async reset mid-countdown
    issue_w(5'd9, LAT_DIV); step("rs_fire", 1'b0);
    use_src(5'd9, 5'd0); step("rs_stall", 1'b1);
    #1; rst_n = 1'b0; #1;
    chk("rs_stall_cycles", stall_cycles, 32'd0);
    chk("rs_issue_stall", {31'd0, iss.issue_stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; idle();
    exp_sc = 0; now = 0;
    for (int r = 0; r < 32; r++) begin busy_m[r] = 1'b0; ready_m[r] = 0; end
    @(negedge clk);

    // randomized run against the ready-time model
    for (int c = 0; c < 1500; c++) begin
      iss.issue_valid    = ($urandom_range(0, 3) != 0);
      iss.issue_regwrite = $urandom_range(0, 1);
      iss.issue_rd       = AW'($urandom_range(0, 7));
      iss.issue_lat      = ($urandom_range(0, 15) == 0) ? 4'd15 : LAT_W'($urandom_range(0, 9));
      iss.issue_src      = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
      iss.issue_src_used = 2'($urandom_range(0, 3));
      iss.src_raw_data   = {$urandom(), $urandom()};
      fwd_valid          = 2'($urandom_range(0, 3));
      fwd_rd             = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
      fwd_data           = {$urandom(), $urandom()};
      retire_valid       = ($urandom_range(0, 2) == 0);
      retire_rd          = AW'($urandom_range(0, 7));
      flush              = ($urandom_range(0, 39) == 0);
      #1;
      raw_h = 1'b0;
      for (int k = 0; k < NSRC; k++) begin
        s = iss.issue_src[k*AW +: AW];
        if (iss.issue_src_used[k] && s != 0 && busy_m[s] && ready_m[s] > now) raw_h = 1'b1;
        ed = iss.src_raw_data[k*XLEN +: XLEN];
        for (int p = NFWD - 1; p >= 0; p--)
          if (fwd_valid[p] && fwd_rd[p*AW +: AW] == s && s != 0) ed = fwd_data[p*XLEN +: XLEN];
        if (s == 0) ed = '0;
        chk($sformatf("rnd%0d_src%0d", c, k), iss.src_data[k*XLEN +: XLEN], ed);
      end
      waw_h = iss.issue_regwrite && iss.issue_rd != 0 && busy_m[iss.issue_rd] &&
              (ready_m[iss.issue_rd] - now) > longint'(iss.issue_lat);
      exp_stall = iss.issue_valid && (raw_h || waw_h);
      chk($sformatf("rnd%0d_stall", c), {31'd0, iss.issue_stall}, {31'd0, exp_stall});
      chk($sformatf("rnd%0d_stall_cycles", c), stall_cycles, exp_sc);
      if (exp_stall) exp_sc++;
      fire = iss.issue_valid && !exp_stall && iss.issue_regwrite && iss.issue_rd != 0;
      if (flush) begin
        for (int r = 0; r < 32; r++) busy_m[r] = 1'b0;
      end else begin
        if (retire_valid && retire_rd != 0) busy_m[retire_rd] = 1'b0;
        if (fire) begin
          busy_m[iss.issue_rd]  = 1'b1;
          ready_m[iss.issue_rd] = now + 1 + longint'(iss.issue_lat);
        end
      end
      now++;
      @(posedge clk); @(negedge clk);
    end
    #1;
    chk("final_stall_cycles", stall_cycles, exp_sc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard_fwd.md
Name: hazard_scoreboard_fwd

Overview:
- Parametrised successor to the pipeline operand-forwarding logic.
- Adds a per-register scoreboard that tracks in-flight writes, including variable-latency ones (loads, mul/div).
- Raises an issue stall when a source is not yet forwardable, and applies N-port priority forwarding with x0 excluded.
- Sits between decode/issue and EX; serves NSRC source operands per issued instruction.

Parameters:
- XLEN, 32, datapath width.
- NREG, 32, architectural registers; AW = clog2(NREG).
- NSRC, 2, source operands checked/forwarded per issue.
- NFWD, 2, forwarding ports; index 0 is youngest and has highest priority (MEM, then WB).
- LAT_W, 4, width of the latency countdown.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- issue_valid  in  1  instruction presented for issue.
- issue_regwrite  in  1  instruction writes rd.
- issue_rd  in  AW  destination register.
- issue_lat  in  LAT_W  cycles until the result appears on a forward port; 0 = ALU result is visible on port 0 next cycle.
- issue_src  in  NSRC*AW  source register addresses.
- issue_src_used  in  NSRC  per-source valid.
- issue_stall  out  1  hold the issuing instruction.
- src_raw_data  in  NSRC*XLEN  register-file read data.
- src_data  out  NSRC*XLEN  forwarded operand data.
- fwd_valid  in  NFWD  port carries a register write.
- fwd_rd  in  NFWD*AW  port destination.
- fwd_data  in  NFWD*XLEN  port data.
- retire_valid  in  1  register-file write this cycle.
- retire_rd  in  AW  register written.
- flush  in  1  pipeline drain/trap; clears the scoreboard.
- stall_cycles  out  32  saturating count of stalled issue cycles.

Behaviour:
- Reset (async, rst_n=0):
  - all busy bits = 0, all counters = 0, stall_cycles = 0.
  - issue_stall = 0; src_data follows the combinational rules below.
- Scoreboard, per register r: busy[r] (1 bit), cnt[r] (LAT_W bits).
- Issue accept (fire) = issue_valid & ~issue_stall & issue_regwrite & (issue_rd != 0).
  - On fire: busy[issue_rd] <= 1, cnt[issue_rd] <= issue_lat.
- Countdown: each cycle, every busy entry with cnt != 0 decrements by 1. It saturates at 0 and never wraps.
- Retire: retire_valid & (retire_rd != 0) clears busy[retire_rd] next cycle.
- Simultaneous fire and retire on the same register: fire wins (busy = 1, cnt = issue_lat).
- x0 is never marked busy, never stalls, and is never forwarded; its src_data is forced to 0.
- issue_stall (combinational) = issue_valid & (RAW | WAW):
  - RAW: any used source s with src != 0, busy[src] = 1 and cnt[src] != 0.
  - WAW: issue_regwrite, issue_rd != 0, busy[issue_rd] = 1 and cnt[issue_rd] > issue_lat. Younger results must not overtake older ones.
- Forwarding, per source (combinational):
  - If src == 0: output 0.
  - Else use the lowest-index port i with fwd_valid[i] & (fwd_rd[i] == src).
  - Else use src_raw_data.
  - Port rd == 0 never matches.
  - Forwarding applies regardless of issue_stall.
- stall_cycles increments each cycle issue_stall = 1 and saturates at 2^32-1.
- flush:
  - Next cycle, all busy bits and counters clear; a fire in the same cycle is discarded.
  - stall_cycles is unaffected.
  - Killing in-flight multi-cycle units is the caller's responsibility.
- No outputs are registered except stall_cycles.
- Scoreboard latency: 1 cycle from fire to busy visible.

Decomposition:
- Shared package (riscvx_pkg):
  - XLEN, NREG, AW constants.
  - x0 index constant.
  - LAT_ALU = 0, LAT_LOAD = 1, LAT_MUL, LAT_DIV.
- One natural sub-module: fwd_mux_prio. One instance per source; a parametrised NFWD-port priority compare/mux with x0 zeroing.
- Scoreboard and stall logic stay in the top module.

Test Plan:
- ALU back-to-back: issue x5 with lat 0, next cycle issue src x5 with fwd port 0 = {x5, 0x1234} -> no stall, src_data = 0x1234.
- Load-use: issue x7 with lat 1, next cycle use x7 -> stall exactly 1 cycle, then the port-0 value is forwarded; stall_cycles = 1.
- Divider: issue x9 with lat 8, then use x9 -> stall 8 cycles. An independent src x3 in the same window also stalls (in-order), and stall_cycles increases by 8.
- x0 and priority:
  - src x0 with port0 = {x0, 0xFF} -> src_data = 0, no stall.
  - src x4 with port0 = {x4, 0xA} and port1 = {x4, 0xB} -> 0xA.
- WAW plus simultaneous fire/retire:
  - x6 with lat 6 pending, issue x6 with lat 0 -> stall.
  - Fire x6 in the same cycle as retire x6 -> busy[x6] = 1 afterwards.
- flush and reset:
  - flush during an 8-cycle busy x9 -> next cycle a use of x9 has no stall.
  - rst_n low mid-countdown -> busy clears immediately and stall_cycles = 0.
